// File: rtl/sm83_irq_sequencer.sv
// sm83_irq_sequencer: SM83 interrupt state (IF, IME, EI delay) and 5-M-cycle dispatch sequencer
//
// Optional feature macro: SM83_HALT_BUG_EN (adds halt_cmd input and halt_bug output).
//
// Ports:
//   clk, rst              core T-cycle clock, async active-high reset
//   mcyc_stb              pulse on the last T-cycle of each M-cycle
//   instr_bnd             opcode-fetch boundary, qualified by mcyc_stb
//   irq_src               one-clk request pulses from peripherals
//   if_wr, if_wdata       CPU write to FF0F
//   if_rdata              FF0F read value {3'b111, IF}
//   ie                    IE[4:0] from the register file
//   ei_cmd/di_cmd/reti_cmd  EI / DI / RETI executed
//   pc_in                 current PC
//   busy                  dispatch in progress, decoder stalls
//   sp_dec, push_wr       SP decrement and push strobes (level per M-cycle)
//   push_data             byte pushed this M-cycle
//   pc_load, pc_vec       PC load strobe and dispatch target
//   wake                  |(IF & IE), HALT exit regardless of IME
//   ime                   current IME
//   halt_cmd, halt_bug    (SM83_HALT_BUG_EN only) HALT request and one-M-cycle HALT-bug pulse
module sm83_irq_sequencer #(
   parameter int          N_IRQ    = 5,
   parameter logic [15:0] VEC_BASE = 16'h0040
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             mcyc_stb,
   input  logic             instr_bnd,
   input  logic [N_IRQ-1:0] irq_src,
   input  logic             if_wr,
   input  logic [N_IRQ-1:0] if_wdata,
   output logic [7:0]       if_rdata,
   input  logic [N_IRQ-1:0] ie,
   input  logic             ei_cmd,
   input  logic             di_cmd,
   input  logic             reti_cmd,
   input  logic [15:0]      pc_in,
   output logic             busy,
   output logic             sp_dec,
   output logic             push_wr,
   output logic [7:0]       push_data,
   output logic             pc_load,
   output logic [15:0]      pc_vec,
   output logic             wake,
`ifdef SM83_HALT_BUG_EN
   input  logic             halt_cmd,
   output logic             halt_bug,
`endif
   output logic             ime
);
   localparam int SW = $clog2(N_IRQ);
   typedef enum logic [2:0] {IDLE, W1, W2, PUSH_HI, PUSH_LO, JUMP} state_t;
   state_t           state;
   logic [N_IRQ-1:0] if_q;
   logic [N_IRQ-1:0] pend;
   logic [N_IRQ-1:0] clr_mask;
   logic [SW-1:0]    sel;
   logic             sel_none;
   logic             ei_pend;
   logic             stb_bnd;
   logic             take;

   // bit 0 has the highest priority
   function automatic logic [SW-1:0] low_idx(input logic [N_IRQ-1:0] v);
      low_idx = '0;
      for (int i = N_IRQ - 1; i >= 0; i--)
         if (v[i]) low_idx = SW'(i);
   endfunction

   always_comb begin
      pend     = if_q & ie;
      stb_bnd  = mcyc_stb & instr_bnd;
      take     = (state == IDLE) && stb_bnd && ime && (|pend);
      clr_mask = (state == JUMP && mcyc_stb && !sel_none) ? (N_IRQ'(1) << sel) : '0;
   end

   assign wake     = |pend;
   assign if_rdata = {{(8 - N_IRQ){1'b1}}, if_q};

   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         state     <= IDLE;
         if_q      <= '0;
         ime       <= 1'b0;
         ei_pend   <= 1'b0;
         sel       <= '0;
         sel_none  <= 1'b0;
         busy      <= 1'b0;
         sp_dec    <= 1'b0;
         push_wr   <= 1'b0;
         push_data <= 8'h00;
         pc_load   <= 1'b0;
         pc_vec    <= 16'h0000;
      end else begin
         // a fresh request always wins over a write or a dispatch clear of the same bit
         if_q <= ((if_wr ? if_wdata : if_q) & ~clr_mask) | irq_src;
         if (state == IDLE) begin
            if (take || di_cmd) begin
               ime     <= 1'b0;
               ei_pend <= 1'b0;
            end else begin
               // EI takes effect one boundary late so exactly one more instruction runs
               if (reti_cmd || (stb_bnd && ei_pend)) ime <= 1'b1;
               if (ei_cmd) ei_pend <= 1'b1;
               else if (stb_bnd) ei_pend <= 1'b0;
            end
         end
         if (mcyc_stb)
            case (state)
               IDLE: if (take) begin
                  state <= W1;
                  busy  <= 1'b1;
               end
               W1: state <= W2;
               W2: begin
                  state     <= PUSH_HI;
                  sp_dec    <= 1'b1;
                  push_wr   <= 1'b1;
                  push_data <= pc_in[15:8];
               end
               PUSH_HI: begin
                  // the high push may have overwritten IE, so resolve only now
                  state     <= PUSH_LO;
                  push_data <= pc_in[7:0];
                  sel       <= low_idx(pend);
                  sel_none  <= ~|pend;
                  pc_vec    <= (|pend) ? VEC_BASE + 16'({low_idx(pend), 3'b000}) : 16'h0000;
               end
               PUSH_LO: begin
                  state     <= JUMP;
                  sp_dec    <= 1'b0;
                  push_wr   <= 1'b0;
                  push_data <= 8'h00;
                  pc_load   <= 1'b1;
               end
               JUMP: begin
                  state   <= IDLE;
                  pc_load <= 1'b0;
                  busy    <= 1'b0;
               end
               default: state <= IDLE;
            endcase
      end

`ifdef SM83_HALT_BUG_EN
   always_ff @(posedge clk or posedge rst)
      if (rst) halt_bug <= 1'b0;
      else if (mcyc_stb) halt_bug <= halt_cmd && !ime && (|pend) && (state == IDLE);
`endif
endmodule

// File: tb/tb_sm83_irq_sequencer.sv
// tb_sm83_irq_sequencer: self-checking bench with a behavioural interrupt model and random stimulus
module tb_sm83_irq_sequencer;
   logic        clk, rst, mcyc_stb, instr_bnd, if_wr, ei_cmd, di_cmd, reti_cmd;
   logic [4:0]  irq_src, if_wdata, ie;
   logic [15:0] pc_in;
   logic [7:0]  if_rdata, push_data;
   logic        busy, sp_dec, push_wr, pc_load, wake, ime;
   logic [15:0] pc_vec;
`ifdef SM83_HALT_BUG_EN
   logic        halt_cmd, halt_bug;
`endif

   int checks = 0;
   int failures = 0;

   // model state: ph counts dispatch M-cycles (0 = not dispatching, 1..5 = W1..JUMP)
   int m_if = 0, m_ime = 0, m_eip = 0, ph = 0, m_sel = -1, m_vec = 0;
   int pend, clr, start;

   sm83_irq_sequencer dut (
      .clk(clk), .rst(rst), .mcyc_stb(mcyc_stb), .instr_bnd(instr_bnd),
      .irq_src(irq_src), .if_wr(if_wr), .if_wdata(if_wdata), .if_rdata(if_rdata),
      .ie(ie), .ei_cmd(ei_cmd), .di_cmd(di_cmd), .reti_cmd(reti_cmd), .pc_in(pc_in),
      .busy(busy), .sp_dec(sp_dec), .push_wr(push_wr), .push_data(push_data),
      .pc_load(pc_load), .pc_vec(pc_vec), .wake(wake),
`ifdef SM83_HALT_BUG_EN
      .halt_cmd(halt_cmd), .halt_bug(halt_bug),
`endif
      .ime(ime)
   );

   initial begin
      clk = 0;
      forever #5 clk = ~clk;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached, actual=running required=finished");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
      checks++;
      if (a !== e) begin
         failures++;
         $display("FAIL %s: actual=%0h required=%0h at %0t", n, a, e, $time);
      end
   endtask

   // reference model, updated on the same edges the DUT sees
   initial forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
         m_if = 0; m_ime = 0; m_eip = 0; ph = 0; m_sel = -1; m_vec = 0;
      end else begin
         pend  = m_if & int'(ie);
         clr   = (mcyc_stb && ph == 5 && m_sel >= 0) ? (1 << m_sel) : 0;
         start = 0;
         if (ph == 0) begin
            if (mcyc_stb && instr_bnd && m_ime != 0 && pend != 0) begin
               m_ime = 0; m_eip = 0; start = 1;
            end else if (di_cmd) begin
               m_ime = 0; m_eip = 0;
            end else begin
               if (reti_cmd || (mcyc_stb && instr_bnd && m_eip != 0)) m_ime = 1;
               if (ei_cmd) m_eip = 1;
               else if (mcyc_stb && instr_bnd) m_eip = 0;
            end
         end
         if (mcyc_stb) begin
            if (ph == 3) begin
               m_sel = (pend == 0) ? -1 : $clog2(pend & -pend);
               m_vec = (m_sel < 0) ? 0 : 'h40 + 8 * m_sel;
            end
            ph = (ph == 5) ? 0 : (ph > 0) ? ph + 1 : start;
         end
         m_if = (((if_wr ? int'(if_wdata) : m_if) & ~clr) | int'(irq_src)) & 'h1F;
      end
   end

   // compare process: every cycle outside reset
   initial forever begin
      @(negedge clk);
      if (!rst) begin
         chk("busy", busy, ph != 0);
         chk("sp_dec", sp_dec, ph == 3 || ph == 4);
         chk("push_wr", push_wr, ph == 3 || ph == 4);
         chk("push_data", push_data, ph == 3 ? pc_in[15:8] : ph == 4 ? pc_in[7:0] : 8'h00);
         chk("pc_load", pc_load, ph == 5);
         if (ph == 5) chk("pc_vec", pc_vec, m_vec);
         chk("if_rdata", if_rdata, 32'hE0 | m_if);
         chk("wake", wake, (m_if & int'(ie)) != 0);
         chk("ime", ime, m_ime);
      end
   end

   task automatic clk1();
      @(posedge clk);
      #1;
      irq_src = 0; if_wr = 0; mcyc_stb = 0; instr_bnd = 0;
      ei_cmd = 0; di_cmd = 0; reti_cmd = 0;
`ifdef SM83_HALT_BUG_EN
      halt_cmd = 0;
`endif
   endtask

   task automatic mcyc(input bit bnd, input bit e, input bit d, input bit r);
      repeat (3) clk1();
      mcyc_stb = 1; instr_bnd = bnd; ei_cmd = e; di_cmd = d; reti_cmd = r;
      clk1();
   endtask

   // run an already-started dispatch to completion, recording what it produced
   task automatic run_dispatch(output int n, output logic [15:0] vec, output logic [15:0] pushed);
      n = 0; vec = 16'hFFFF; pushed = 16'hFFFF;
      while (busy && n < 10) begin
         if (push_wr && sp_dec) pushed = {pushed[7:0], push_data};
         if (pc_load) vec = pc_vec;
         mcyc(0, 0, 0, 0);
         n++;
      end
   endtask

   int n;
   logic [15:0] vec, pushed;

   initial begin
      rst = 1; ie = 0; pc_in = 16'h1234; if_wdata = 0;
      irq_src = 0; if_wr = 0; mcyc_stb = 0; instr_bnd = 0;
      ei_cmd = 0; di_cmd = 0; reti_cmd = 0;
`ifdef SM83_HALT_BUG_EN
      halt_cmd = 0;
`endif
      repeat (2) @(posedge clk);
      #1;
      chk("rst_if_rdata", if_rdata, 8'hE0);
      chk("rst_busy", busy, 0);
      chk("rst_ime", ime, 0);
      chk("rst_pc_vec", pc_vec, 16'h0000);
      chk("rst_push_data", push_data, 8'h00);
      rst = 0;
      clk1();

      // basic VBlank dispatch
      ie = 5'h01; irq_src = 5'h01; clk1();
      mcyc(0, 0, 0, 1);
      chk("s1_ime_set", ime, 1);
      mcyc(1, 0, 0, 0);
      run_dispatch(n, vec, pushed);
      chk("s1_busy_mcycles", n, 5);
      chk("s1_vec", vec, 16'h0040);
      chk("s1_pushed", pushed, 16'h1234);
      chk("s1_if_after", if_rdata, 8'hE0);
      chk("s1_ime_after", ime, 0);

      // priority: IF=14, IE=1F -> Timer vector, STAT left? no: bit2 served, bit4 left
      if_wr = 1; if_wdata = 5'h14; ie = 5'h1F; clk1();
      mcyc(0, 0, 0, 1);
      mcyc(1, 0, 0, 0);
      run_dispatch(n, vec, pushed);
      chk("s2_vec", vec, 16'h0050);
      chk("s2_if_after", if_rdata, 8'hF0);
      if_wr = 1; if_wdata = 0; clk1();

      // EI then NOP
      ie = 5'h01; irq_src = 5'h01; clk1();
      mcyc(0, 1, 0, 0);
      mcyc(1, 0, 0, 0);
      chk("s3_no_disp_after_ei", busy, 0);
      chk("s3_ime_after_ei", ime, 1);
      mcyc(1, 0, 0, 0);
      chk("s3_disp_after_nop", busy, 1);
      run_dispatch(n, vec, pushed);
      chk("s3_vec", vec, 16'h0040);

      // EI;DI never dispatches
      irq_src = 5'h01; clk1();
      mcyc(0, 1, 0, 0);
      mcyc(1, 0, 1, 0);
      repeat (3) begin
         mcyc(1, 0, 0, 0);
         chk("s4_eidi_no_disp", busy, 0);
      end
      chk("s4_eidi_ime", ime, 0);

      // IE overwritten during PUSH_HI -> vector 0, IF untouched
      mcyc(0, 0, 0, 1);
      mcyc(1, 0, 0, 0);
      mcyc(0, 0, 0, 0);
      mcyc(0, 0, 0, 0);
      chk("s5_in_push_hi", push_wr, 1);
      ie = 5'h00;
      run_dispatch(n, vec, pushed);
      chk("s5_vec_none", vec, 16'h0000);
      chk("s5_if_kept", if_rdata, 8'hE1);
      if_wr = 1; if_wdata = 0; clk1();

      // set beats clear on a collision
      if_wr = 1; if_wdata = 5'h04; clk1();
      if_wr = 1; if_wdata = 5'h00; irq_src = 5'h04; clk1();
      chk("s6_collision", if_rdata, 8'hE4);

      // reset in PUSH_LO
      ie = 5'h04;
      mcyc(0, 0, 0, 1);
      mcyc(1, 0, 0, 0);
      repeat (3) mcyc(0, 0, 0, 0);
      chk("s7_in_push_lo", push_data, 8'h34);
      rst = 1;
      #1;
      chk("s7_rst_busy", busy, 0);
      chk("s7_rst_ime", ime, 0);
      chk("s7_rst_if", if_rdata, 8'hE0);
      @(posedge clk);
      #1;
      rst = 0;
      clk1();

`ifdef SM83_HALT_BUG_EN
      ie = 5'h01; irq_src = 5'h01; clk1();
      repeat (3) clk1();
      mcyc_stb = 1; halt_cmd = 1;
      clk1();
      chk("s8_halt_bug_on", halt_bug, 1);
      mcyc(0, 0, 0, 0);
      chk("s8_halt_bug_off", halt_bug, 0);
      if_wr = 1; if_wdata = 0; clk1();
`endif

      // random phase
      for (int k = 0; k < 3000; k++) begin
         for (int t = 0; t < 4; t++) begin
            irq_src  = ($urandom % 12 == 0) ? 5'($urandom) : 5'h00;
            if_wr    = ($urandom % 40 == 0);
            if_wdata = 5'($urandom);
            if (ph == 0 && $urandom % 8 == 0) ie = 5'($urandom);
            else if ($urandom % 64 == 0) ie = 5'($urandom);
            if (ph == 0) pc_in = 16'($urandom);
            if (t == 3) begin
               mcyc_stb  = 1;
               instr_bnd = 1'($urandom % 2);
               if (ph == 0) begin
                  ei_cmd   = ($urandom % 8 == 0);
                  di_cmd   = ($urandom % 16 == 0);
                  reti_cmd = ($urandom % 10 == 0);
               end
            end
            clk1();
         end
         if ($urandom % 400 == 0) begin
            rst = 1;
            clk1();
            rst = 0;
         end
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
